count_timer: RTL and testbench
==============================

# count_timer

Sequential wrapper around the 16-bit loadable down-counter next-state logic. It holds the counter state register and drives the load, enable and clear controls. It detects expiry and queues expiry events for a downstream consumer over a valid/ready port. It is the stage that feeds state into the counter logic and consumes the next state it produces.

## Interface
- WIDTH, 16, counter and load-value width in bits.
- EVT_DEPTH, 4, maximum number of pending (unacknowledged) expiry events; ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of count, state, reload, pending events and overflow.
- load  input  1  synchronous load of load_val into count and reload register.
- load_val  input  WIDTH  value captured on load.
- en  input  1  count enable; decrement only when high.
- count  output  WIDTH  current counter value (registered).
- running  output  1  high while state is RUN.
- tc  output  1  one-cycle terminal-count pulse (registered).
- evt_valid  output  1  at least one expiry event pending.
- evt_ready  input  1  consumer accepts one event when evt_valid is also high.
- evt_overflow  output  1  sticky; an expiry was dropped because the event queue was full.

## Operation
- States: IDLE, RUN, EXPIRED. Reset: state IDLE, count 0, reload 0, tc 0, pending 0, evt_valid 0, evt_overflow 0, running 0.
- Priority each cycle: clr > load > decrement.
- clr: count←0, reload←0, state←IDLE, pending←0, evt_overflow←0, tc←0. clr overrides a same-cycle load, expiry or pop.
- load:
  - count←load_val and reload←load_val.
  - State←RUN if load_val≠0; otherwise state←IDLE and no event is raised.
  - Load in any state, including mid-count in RUN, restarts the count. Load takes priority over a coincident expiry: no tc and no event.
- RUN with en=1:
  - count>1: count←count−1.
  - count==1: expiry. tc←1 for the next cycle and the expiry event is offered to the queue. The count and state update depends on the Configuration macro.
- RUN with en=0: count and state hold. In IDLE and EXPIRED, en is ignored.
- Event queue: `pending` counts from 0 to EVT_DEPTH.
  - evt_valid = (pending≠0).
  - A pop happens when evt_valid && evt_ready.
  - Expiry alone: pending+1. Pop alone: pending−1. Expiry and pop together: pending unchanged.
  - Expiry while pending==EVT_DEPTH with no pop: event dropped, evt_overflow←1. Expiry while full with a pop in the same cycle is accepted with no overflow.
- Arithmetic is unsigned WIDTH bits. The decrement never wraps because expiry is taken at 1. Maximum interval is 2^WIDTH−1 enabled cycles.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Load at edge N with load_val=L≥1 and en held high:
  - count=L after edge N, L−k after edge N+k.
  - Expiry at edge N+L: tc=1 and evt_valid=1 during cycle N+L.
- en low cycles stretch the interval by one cycle each.
- tc is high for exactly one cycle per expiry. Back-to-back expiries, possible when reload=1 with autoreload, give tc high continuously, once per cycle.
- evt_valid deasserts the cycle after the last pending event is popped.
- rst asserted mid-count returns every output to its reset value immediately, without waiting for a clock edge. Release is synchronous to the next clk edge.

## Configuration
- COUNT_TIMER_AUTORELOAD_EN defined: on expiry, count←reload and state stays RUN, giving a periodic timer with period reload cycles. EXPIRED is unreachable.
- COUNT_TIMER_AUTORELOAD_EN undefined: on expiry, count←0 and state←EXPIRED (running=0). The timer holds until the next load or clr.

## Test plan
- Reset, then load L=5 with en=1 held -> count 5,4,3,2,1 on successive cycles. tc=1 and evt_valid=1 exactly 5 cycles after the load edge. Without autoreload, count=0 and running=0 thereafter.
- Load 3 with en toggling 1,0,1,0,1 -> expiry after the 3rd enabled cycle (5 cycles after load); count holds during en=0 cycles.
- Autoreload build, load 2, en=1, evt_ready=1 -> tc on every 2nd cycle, count alternates 2,1, pending stays ≤1.
- evt_ready=0 with EVT_DEPTH=4 and autoreload period 1 -> pending reaches 4; the 5th expiry sets evt_overflow. Then a cycle with expiry and pop together while pending=4 -> pending stays 4, no new overflow.
- Load and clr in the same cycle, and load coincident with expiry -> clr wins (count 0, IDLE); load wins over expiry (no tc, no event).
- Assert rst while count=7 and pending=2 -> all outputs return to reset values asynchronously without a clk edge.

Source files
------------

// File: rtl/count_timer_if.sv
// Control and event port bundle for count_timer: load/clear/enable inputs,
// counter status outputs and the valid/ready expiry-event handshake.
interface count_timer_if #(
   parameter int WIDTH = 16
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic [WIDTH-1:0] count;
   logic             running;
   logic             tc;
   logic             evt_valid;
   logic             evt_ready;
   logic             evt_overflow;

   modport master (
      output clr, load, load_val, en, evt_ready,
      input  count, running, tc, evt_valid, evt_overflow
   );

   modport slave (
      input  clr, load, load_val, en, evt_ready,
      output count, running, tc, evt_valid, evt_overflow
   );
endinterface

// File: rtl/count_timer.sv
// Loadable down-counter timer with an expiry-event queue (valid/ready).
// Define COUNT_TIMER_AUTORELOAD_EN for periodic reload on expiry instead of halting in EXPIRED.
module count_timer #(
   parameter int WIDTH     = 16,
   parameter int EVT_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   count_timer_if.slave bus
);
   localparam int             PW     = $clog2(EVT_DEPTH + 1);
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
   localparam logic [PW-1:0]    FULL_C = PW'(EVT_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   state_e           state_q,   state_d;
   logic [WIDTH-1:0] count_q,   count_d;
   logic [WIDTH-1:0] reload_q,  reload_d;
   logic [PW-1:0]    pending_q, pending_d;
   logic             tc_q,      tc_d;
   logic             ovf_q,     ovf_d;
   logic             valid_q,   valid_d;
   logic             running_q, running_d;
   logic             expire_s;
   logic             pop_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= {WIDTH{1'b0}};
         reload_q  <= {WIDTH{1'b0}};
         pending_q <= {PW{1'b0}};
         tc_q      <= 1'b0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         pending_q <= pending_d;
         tc_q      <= tc_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
         running_q <= running_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      reload_d  = reload_q;
      pending_d = pending_q;
      tc_d      = 1'b0;
      ovf_d     = ovf_q;
      expire_s  = 1'b0;
      pop_s     = valid_q && bus.evt_ready;

      // Counter control: clr beats load, load beats a coincident expiry.
      if (bus.clr) begin
         state_d  = ST_IDLE;
         count_d  = {WIDTH{1'b0}};
         reload_d = {WIDTH{1'b0}};
      end else if (bus.load) begin
         count_d  = bus.load_val;
         reload_d = bus.load_val;
         state_d  = (bus.load_val != {WIDTH{1'b0}}) ? ST_RUN : ST_IDLE;
      end else if ((state_q == ST_RUN) && bus.en) begin
         if (count_q == ONE_C) begin
            expire_s = 1'b1;
            tc_d     = 1'b1;
`ifdef COUNT_TIMER_AUTORELOAD_EN
            count_d  = reload_q;
            state_d  = ST_RUN;
`else
            count_d  = {WIDTH{1'b0}};
            state_d  = ST_EXPIRED;
`endif
         end else begin
            count_d = count_q - ONE_C;
         end
      end else begin
         state_d = state_q;
         count_d = count_q;
      end

      // A full queue still accepts an expiry when a pop frees a slot in the same cycle.
      if (bus.clr) begin
         pending_d = {PW{1'b0}};
         ovf_d     = 1'b0;
      end else begin
         case ({expire_s, pop_s})
            2'b10: begin
               if (pending_q == FULL_C) begin
                  ovf_d = 1'b1;
               end else begin
                  pending_d = pending_q + PW'(1);
               end
            end
            2'b01:   pending_d = pending_q - PW'(1);
            default: pending_d = pending_q;
         endcase
      end

      valid_d   = (pending_d != {PW{1'b0}});
      running_d = (state_d == ST_RUN);
   end

   assign bus.count        = count_q;
   assign bus.running      = running_q;
   assign bus.tc           = tc_q;
   assign bus.evt_valid    = valid_q;
   assign bus.evt_overflow = ovf_q;
endmodule

// File: tb/tb_count_timer.sv
// Directed self-checking bench for count_timer; covers both builds of
// COUNT_TIMER_AUTORELOAD_EN where expected values differ.
module tb_count_timer;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   count_timer_if #(.WIDTH(16)) bus ();

   count_timer #(.WIDTH(16), .EVT_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [15:0] c, input logic r,
                          input logic t, input logic v, input logic o);
      chk({tag, ".count"}, 32'(bus.count), 32'(c));
      chk({tag, ".running"}, 32'(bus.running), 32'(r));
      chk({tag, ".tc"}, 32'(bus.tc), 32'(t));
      chk({tag, ".evt_valid"}, 32'(bus.evt_valid), 32'(v));
      chk({tag, ".ovf"}, 32'(bus.evt_overflow), 32'(o));
   endtask

   // One expiry: load 1 with en low, then a single enabled cycle; rdy drives evt_ready on that edge.
   task automatic expire_once(input logic rdy);
      bus.evt_ready = 1'b0;
      bus.load = 1'b1; bus.load_val = 16'd1; bus.en = 1'b0;
      step();
      bus.load = 1'b0; bus.en = 1'b1; bus.evt_ready = rdy;
      step();
      bus.en = 1'b0; bus.evt_ready = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 16'd0;
      bus.en = 1'b0; bus.evt_ready = 1'b0;
      repeat (2) step();
      chk_all("reset", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step();

      // Load 5 with en held high.
      bus.load = 1'b1; bus.load_val = 16'd5; bus.en = 1'b1;
      step();
      bus.load = 1'b0;
      chk_all("l5.k0", 16'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("l5.count", 32'(bus.count), 32'(5 - k));
         chk("l5.tc", 32'(bus.tc), 32'd0);
      end
      step();
`ifdef COUNT_TIMER_AUTORELOAD_EN
      chk_all("l5.exp", 16'd5, 1'b1, 1'b1, 1'b1, 1'b0);
`else
      chk_all("l5.exp", 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
      bus.en = 1'b0; bus.evt_ready = 1'b1;
      step();
      bus.evt_ready = 1'b0;
`ifdef COUNT_TIMER_AUTORELOAD_EN
      chk_all("l5.pop", 16'd5, 1'b1, 1'b0, 1'b0, 1'b0);
`else
      chk_all("l5.pop", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      // Load 3, en toggles 1,0,1,0,1: expiry 5 cycles after load.
      bus.load = 1'b1; bus.load_val = 16'd3; bus.en = 1'b0;
      step();
      bus.load = 1'b0;
      chk("l3.k0", 32'(bus.count), 32'd3);
      bus.en = 1'b1; step(); chk("l3.k1", 32'(bus.count), 32'd2);
      bus.en = 1'b0; step(); chk("l3.k2", 32'(bus.count), 32'd2);
      bus.en = 1'b1; step(); chk("l3.k3", 32'(bus.count), 32'd1);
      bus.en = 1'b0; step(); chk("l3.k4", 32'(bus.count), 32'd1);
      chk("l3.k4.tc", 32'(bus.tc), 32'd0);
      bus.en = 1'b1; step();
      chk("l3.k5.tc", 32'(bus.tc), 32'd1);
      chk("l3.k5.valid", 32'(bus.evt_valid), 32'd1);
      bus.en = 1'b0; bus.evt_ready = 1'b1;
      step();
      bus.evt_ready = 1'b0;
      chk("l3.pop.valid", 32'(bus.evt_valid), 32'd0);

      // clr beats load; load beats expiry; load of zero stays idle.
      bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 16'd9;
      step();
      bus.clr = 1'b0; bus.load = 1'b0;
      chk_all("clr_ld", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.load = 1'b1; bus.load_val = 16'd1; bus.en = 1'b1;
      step();
      bus.load_val = 16'd4;
      step();
      bus.load = 1'b0; bus.en = 1'b0;
      chk_all("ld_exp", 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      bus.load = 1'b1; bus.load_val = 16'd0;
      step();
      bus.load = 1'b0;
      chk_all("ld0", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef COUNT_TIMER_AUTORELOAD_EN
      // Periodic reload of 2 with the consumer always ready.
      bus.load = 1'b1; bus.load_val = 16'd2; bus.en = 1'b1; bus.evt_ready = 1'b1;
      step();
      bus.load = 1'b0;
      chk_all("ar.k0", 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("ar.count", 32'(bus.count), (k % 2 == 1) ? 32'd1 : 32'd2);
         chk("ar.tc", 32'(bus.tc), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("ar.valid", 32'(bus.evt_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      bus.en = 1'b0;
      step();
      bus.evt_ready = 1'b0;
      chk("ar.drain", 32'(bus.evt_valid), 32'd0);
      bus.clr = 1'b1; step(); bus.clr = 1'b0;
`endif

      // Fill the queue, accept expiry+pop while full, then overflow.
      for (int i = 0; i < 4; i++) begin
         expire_once(1'b0);
         chk("fill.tc", 32'(bus.tc), 32'd1);
         chk("fill.valid", 32'(bus.evt_valid), 32'd1);
         chk("fill.ovf", 32'(bus.evt_overflow), 32'd0);
      end
      expire_once(1'b1);
      chk("full_pop.tc", 32'(bus.tc), 32'd1);
      chk("full_pop.ovf", 32'(bus.evt_overflow), 32'd0);
      expire_once(1'b0);
      chk("ovf.set", 32'(bus.evt_overflow), 32'd1);
      bus.evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain.valid", 32'(bus.evt_valid), (i < 3) ? 32'd1 : 32'd0);
      end
      bus.evt_ready = 1'b0;
      chk("ovf.sticky", 32'(bus.evt_overflow), 32'd1);
      bus.clr = 1'b1; step(); bus.clr = 1'b0;
      chk_all("ovf.clr", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset with count 7 and two pending events.
      expire_once(1'b0);
      expire_once(1'b0);
      bus.load = 1'b1; bus.load_val = 16'd7;
      step();
      bus.load = 1'b0;
      chk_all("pre_rst", 16'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 chk_all("async_rst", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b0;
      step();
      chk_all("post_rst", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
